// File: rtl/cache_defs.sv
// cache_defs: line/address widths shared by the dcache and victim cache,
// plus the state type of the dcache-side victim controller.
package cache_defs;
    localparam int DCACHE_LINE_WIDTH = 128;
    localparam int VICTIM_ADDR_BITS  = 28;
    typedef enum logic [2:0] {IDLE, PROBE, MEM, VWRITE, DONE} vc_ctrl_state_t;
endpackage

// File: rtl/vc_sat_counter.sv
// vc_sat_counter: event counter that sticks at all-ones instead of wrapping.
module vc_sat_counter #(
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    output logic [STAT_W-1:0] cnt_o
);
    logic [STAT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/dcache_victim_ctrl.sv
// dcache_victim_ctrl: serves one dcache line miss at a time from the victim cache or
// memory, writes the evicted line into the victim cache, then returns the fill.
module dcache_victim_ctrl
    import cache_defs::*;
#(
    parameter int LINE_W  = DCACHE_LINE_WIDTH,
    parameter int VADDR_W = VICTIM_ADDR_BITS,
    parameter int STAT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               miss_req_i,
    input  logic [VADDR_W-1:0] miss_addr_i,
    input  logic               evict_valid_i,
    input  logic [VADDR_W-1:0] evict_addr_i,
    input  logic [LINE_W-1:0]  evict_data_i,
    output logic               miss_ack_o,
    output logic [LINE_W-1:0]  fill_data_o,
    output logic               fill_src_o,
    output logic [VADDR_W-1:0] vc_addr_o,
    output logic [LINE_W-1:0]  vc_data_o,
    output logic               vc_wr_en_o,
    input  logic [LINE_W-1:0]  vc_data_i,
    input  logic               vc_hit_i,
    output logic               mem_req_o,
    output logic [VADDR_W-1:0] mem_addr_o,
    input  logic               mem_ack_i,
    input  logic [LINE_W-1:0]  mem_data_i,
    output logic [STAT_W-1:0]  hit_cnt_o,
    output logic [STAT_W-1:0]  miss_cnt_o
);
    vc_ctrl_state_t     state_q;
    logic [VADDR_W-1:0] miss_addr_q, evict_addr_q, vc_addr_q, mem_addr_q;
    logic [LINE_W-1:0]  evict_data_q, fill_q, fill_d, vc_data_q;
    logic               evict_valid_q, fill_src_q, vc_wr_en_q, mem_req_q, ack_q;
    logic               fill_ok, hit_inc, miss_inc;

    assign fill_ok  = (state_q == PROBE && vc_hit_i) || (state_q == MEM && mem_ack_i);
    assign fill_d   = state_q == PROBE ? vc_data_i : mem_data_i;
    assign hit_inc  = state_q == PROBE && vc_hit_i && !flush_i;
    assign miss_inc = state_q == PROBE && !vc_hit_i && !flush_i;

    // Per-cycle strobes default low; each branch sets what the next state drives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            miss_addr_q   <= '0;
            evict_addr_q  <= '0;
            evict_data_q  <= '0;
            evict_valid_q <= 1'b0;
            fill_q        <= '0;
            fill_src_q    <= 1'b0;
            vc_addr_q     <= '0;
            vc_data_q     <= '0;
            vc_wr_en_q    <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            ack_q         <= 1'b0;
        end else begin
            vc_addr_q  <= '0;
            vc_data_q  <= '0;
            vc_wr_en_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ack_q      <= 1'b0;
            if (flush_i) begin
                state_q <= IDLE;
            end else if (state_q == IDLE) begin
                if (miss_req_i) begin
                    miss_addr_q   <= miss_addr_i;
                    evict_valid_q <= evict_valid_i;
                    evict_addr_q  <= evict_addr_i;
                    evict_data_q  <= evict_data_i;
                    vc_addr_q     <= miss_addr_i;
                    state_q       <= PROBE;
                end
            end else if (fill_ok) begin
                fill_q     <= fill_d;
                fill_src_q <= state_q == PROBE;
                vc_wr_en_q <= evict_valid_q;
                vc_addr_q  <= evict_valid_q ? evict_addr_q : '0;
                vc_data_q  <= evict_valid_q ? evict_data_q : '0;
                ack_q      <= !evict_valid_q;
                state_q    <= evict_valid_q ? VWRITE : DONE;
            end else if (state_q == PROBE || state_q == MEM) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= miss_addr_q;
                state_q    <= MEM;
            end else if (state_q == VWRITE) begin
                ack_q   <= 1'b1;
                state_q <= DONE;
            end else begin
                state_q <= IDLE;
            end
        end
    end

    // Flush must silence the strobes in the very cycle it is raised.
    assign miss_ack_o  = ack_q & ~flush_i;
    assign fill_data_o = miss_ack_o ? fill_q : '0;
    assign fill_src_o  = fill_src_q;
    assign vc_addr_o   = vc_addr_q;
    assign vc_data_o   = vc_data_q;
    assign vc_wr_en_o  = vc_wr_en_q & ~flush_i;
    assign mem_req_o   = mem_req_q & ~flush_i;
    assign mem_addr_o  = mem_addr_q;

    vc_sat_counter #(.STAT_W(STAT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (hit_inc),
        .cnt_o (hit_cnt_o)
    );

    vc_sat_counter #(.STAT_W(STAT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (miss_inc),
        .cnt_o (miss_cnt_o)
    );
endmodule

// File: tb/tb_dcache_victim_ctrl.sv
// tb_dcache_victim_ctrl: directed and randomized misses against a 4-entry victim cache
// and a variable-latency memory, with expectations from a transaction-level model.
module tb_dcache_victim_ctrl;
    localparam int LW = 128, AW = 28, SW = 2;
    localparam logic [LW-1:0] DEAD = {4{32'hDEADDEAD}};
    localparam logic [LW-1:0] BEEF = {4{32'hBEEFBEEF}};
    localparam logic [LW-1:0] CAFE = {4{32'hCAFECAFE}};
    localparam logic [LW-1:0] NEWD = {4{32'h12345678}};

    logic clk = 0, rst = 0, flush_i = 0, miss_req_i = 0, evict_valid_i = 0;
    logic [AW-1:0] miss_addr_i = '0, evict_addr_i = '0;
    logic [LW-1:0] evict_data_i = '0;
    logic miss_ack_o, fill_src_o, vc_wr_en_o, vc_hit_i, mem_req_o, mem_ack_i;
    logic [LW-1:0] fill_data_o, vc_data_o, vc_data_i, mem_data_i;
    logic [AW-1:0] vc_addr_o, mem_addr_o;
    logic [SW-1:0] hit_cnt_o, miss_cnt_o;
    int total = 0, bad = 0, exp_hit = 0, exp_miss = 0;

    dcache_victim_ctrl #(.LINE_W(LW), .VADDR_W(AW), .STAT_W(SW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .miss_req_i(miss_req_i),
        .miss_addr_i(miss_addr_i), .evict_valid_i(evict_valid_i),
        .evict_addr_i(evict_addr_i), .evict_data_i(evict_data_i),
        .miss_ack_o(miss_ack_o), .fill_data_o(fill_data_o), .fill_src_o(fill_src_o),
        .vc_addr_o(vc_addr_o), .vc_data_o(vc_data_o), .vc_wr_en_o(vc_wr_en_o),
        .vc_data_i(vc_data_i), .vc_hit_i(vc_hit_i), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    // Victim cache: fully associative, in-place update or round-robin replacement
    logic [AW-1:0] vtag [4];
    logic [LW-1:0] vline [4];
    logic vval [4] = '{default: 1'b0};
    int rr = 0, wr_cnt = 0;
    logic [AW-1:0] wr_addr = '0, pre_addr = '0;
    logic [LW-1:0] wr_data = '0, pre_data = '0;
    logic pre_en = 0;

    function automatic int find(input logic [AW-1:0] a);
        for (int i = 0; i < 4; i++) if (vval[i] && vtag[i] == a) return i;
        return -1;
    endfunction

    function automatic int nvalid();
        int n = 0;
        for (int i = 0; i < 4; i++) n += int'(vval[i]);
        return n;
    endfunction

    always_comb begin
        vc_hit_i  = 1'b0;
        vc_data_i = {4{32'h5A5A5A5A}};
        for (int i = 0; i < 4; i++)
            if (!vc_wr_en_o && vval[i] && vtag[i] == vc_addr_o) begin
                vc_hit_i  = 1'b1;
                vc_data_i = vline[i];
            end
    end

    always @(posedge clk) begin : vc_write
        int k;
        logic [AW-1:0] a;
        logic [LW-1:0] d;
        if (vc_wr_en_o || pre_en) begin
            a = pre_en ? pre_addr : vc_addr_o;
            d = pre_en ? pre_data : vc_data_o;
            k = find(a);
            if (k < 0) begin
                k = rr;
                rr <= (rr + 1) % 4;
            end
            vtag[k]  <= a;
            vline[k] <= d;
            vval[k]  <= 1'b1;
            if (vc_wr_en_o) begin
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= a;
                wr_data <= d;
            end
        end
    end

    // Memory: acks after mem_wait idle request cycles
    logic ack_auto = 0, ack_force = 0;
    int req_cyc = 0, mem_wait = 0;
    logic [LW-1:0] mem_fill = '0;
    always @(negedge clk) begin
        if (mem_req_o && !ack_auto) begin
            ack_auto <= (req_cyc == mem_wait);
            req_cyc  <= req_cyc + 1;
        end else begin
            ack_auto <= 1'b0;
            req_cyc  <= 0;
        end
    end
    assign mem_ack_i  = ack_auto | ack_force;
    assign mem_data_i = mem_ack_i ? mem_fill : {4{32'h0BADF00D}};

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return v > (1 << SW) - 1 ? (1 << SW) - 1 : v;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [LW-1:0] d);
        @(negedge clk);
        pre_en = 1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 0;
    endtask

    task automatic txn(input logic [AW-1:0] ma, input logic ev, input logic [AW-1:0] ea,
                       input logic [LW-1:0] ed, input int wt, input logic [LW-1:0] mf,
                       output logic [LW-1:0] fill);
        int k, lat, mreq, wr0, exp_lat;
        logic hit, got;
        logic [LW-1:0] exp_fill;
        k = find(ma);
        hit = k >= 0;
        if (hit) exp_fill = vline[k];
        else exp_fill = mf;
        exp_lat  = hit ? (ev ? 3 : 2) : (ev ? 4 : 3) + wt;
        exp_hit  = sat(exp_hit + int'(hit));
        exp_miss = sat(exp_miss + int'(!hit));
        mem_wait = wt; mem_fill = mf; wr0 = wr_cnt;
        fill = '0; got = 0; lat = 0; mreq = 0;
        @(negedge clk);
        chk("idle_vc_addr", vc_addr_o, '0);
        miss_req_i = 1; miss_addr_i = ma; evict_valid_i = ev; evict_addr_i = ea; evict_data_i = ed;
        @(posedge clk);
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_req_o) begin
                mreq++;
                chk("mem_addr", mem_addr_o, ma);
            end
            if (miss_ack_o) begin
                got = 1;
                fill = fill_data_o;
                chk("fill", fill_data_o, exp_fill);
                chk("fill_src", fill_src_o, hit);
            end else chk("fill_zero", fill_data_o, '0);
        end
        miss_req_i = 0; evict_valid_i = 0;
        chk("ack_seen", got, 1);
        chk("latency", lat, exp_lat);
        chk("mem_req_cycles", mreq, hit ? 0 : wt + 1);
        chk("vc_writes", wr_cnt - wr0, ev);
        if (ev) begin
            chk("wr_addr", wr_addr, ea);
            chk("wr_data", wr_data, ed);
        end
        chk("hit_cnt", hit_cnt_o, exp_hit);
        chk("miss_cnt", miss_cnt_o, exp_miss);
    endtask

    initial begin
        logic [LW-1:0] f;
        int w0;
        repeat (3) @(negedge clk);
        chk("rst_ack", miss_ack_o, 0);
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_vc_wr", vc_wr_en_o, 0);
        chk("rst_vc_addr", vc_addr_o, 0);
        chk("rst_fill", fill_data_o, 0);
        chk("rst_hit_cnt", hit_cnt_o, 0);
        chk("rst_miss_cnt", miss_cnt_o, 0);
        rst = 1;

        preload(28'h0000ABC, DEAD);
        txn(28'h0000ABC, 0, '0, '0, 0, '0, f);
        chk("t1_fill", f, DEAD);
        chk("t1_hit_cnt", hit_cnt_o, 1);

        txn(28'h0000123, 1, 28'h0000456, BEEF, 3, CAFE, f);
        chk("t2_fill", f, CAFE);
        chk("t2_miss_cnt", miss_cnt_o, 1);

        txn(28'h0000789, 1, 28'h0000456, NEWD, 0, BEEF, f);
        txn(28'h0000456, 0, '0, '0, 0, '0, f);
        chk("t3_new_data", f, NEWD);
        chk("t3_entries", nvalid(), 2);
        chk("t3_abc_kept", vline[find(28'h0000ABC)], DEAD);

        mem_wait = 1000;
        @(negedge clk);
        miss_req_i = 1; miss_addr_i = 28'h0000777; evict_valid_i = 1;
        evict_addr_i = 28'h0000888; evict_data_i = BEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("fl_req_before", mem_req_o, 1);
        flush_i = 1;
        #1;
        chk("fl_req_drop", mem_req_o, 0);
        miss_req_i = 0; evict_valid_i = 0;
        exp_miss = sat(exp_miss + 1);
        @(posedge clk);
        #1 flush_i = 0;
        w0 = wr_cnt;
        @(negedge clk) ack_force = 1;
        @(negedge clk) ack_force = 0;
        repeat (4) begin
            @(negedge clk);
            chk("fl_no_ack", miss_ack_o, 0);
            chk("fl_no_req", mem_req_o, 0);
            chk("fl_idle_addr", vc_addr_o, 0);
        end
        chk("fl_no_write", wr_cnt - w0, 0);
        chk("fl_miss_cnt", miss_cnt_o, exp_miss);
        txn(28'h0000777, 0, '0, '0, 1, CAFE, f);

        for (int i = 0; i < 24; i++)
            txn(28'h10 + 28'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                28'h10 + 28'($urandom_range(0, 5)), {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 3), {$urandom, $urandom, $urandom, $urandom}, f);

        preload(28'h0000ABC, DEAD);
        @(negedge clk);
        miss_req_i = 1; miss_addr_i = 28'h0000ABC; evict_valid_i = 1; evict_addr_i = 28'h0000999;
        @(posedge clk);
        #1 rst = 0;
        #1;
        chk("ar_ack", miss_ack_o, 0);
        chk("ar_mem_req", mem_req_o, 0);
        chk("ar_vc_wr", vc_wr_en_o, 0);
        chk("ar_vc_addr", vc_addr_o, 0);
        chk("ar_fill_src", fill_src_o, 0);
        chk("ar_hit_cnt", hit_cnt_o, 0);
        chk("ar_miss_cnt", miss_cnt_o, 0);
        miss_req_i = 0; evict_valid_i = 0;
        exp_hit = 0; exp_miss = 0;
        @(negedge clk) rst = 1;
        repeat (4) begin
            @(negedge clk);
            chk("ar_no_ack", miss_ack_o, 0);
        end

        for (int i = 0; i < 5; i++) txn(28'h0000ABC, 0, '0, '0, 0, '0, f);
        chk("sat_hit_cnt", hit_cnt_o, 3);
        chk("sat_miss_cnt", miss_cnt_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_victim_ctrl.md
Name: dcache_victim_ctrl

Overview:
- Dcache-side initiator for the victim cache. It accepts one line-miss at a time from the dcache controller, probes the victim cache, and refills from the victim cache on a hit or from memory on a miss.
- It writes the line the dcache is evicting into the victim cache, then returns the fill line to the dcache.
- It sits between the dcache miss handler, the victim cache, and the memory bus port.
- It also keeps saturating hit and miss statistics.

Parameters:
- LINE_W, 128, cache line width in bits; must equal DCACHE_LINE_WIDTH.
- VADDR_W, 28, tag+index width in bits; must equal VICTIM_ADDR_BITS.
- STAT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous abort/flush
- miss_req_i  in  1  dcache line-miss request, held until miss_ack_o
- miss_addr_i  in  VADDR_W  tag+index of missing line
- evict_valid_i  in  1  a valid line is being evicted with this miss
- evict_addr_i  in  VADDR_W  tag+index of evicted line
- evict_data_i  in  LINE_W  evicted line data
- miss_ack_o  out  1  one-cycle pulse: fill data valid
- fill_data_o  out  LINE_W  fill line, valid only with miss_ack_o
- fill_src_o  out  1  1 = fill came from victim cache, 0 = fill came from memory
- vc_addr_o  out  VADDR_W  victim cache lookup/write address
- vc_data_o  out  LINE_W  victim cache write data
- vc_wr_en_o  out  1  victim cache write enable
- vc_data_i  in  LINE_W  victim cache lookup data (combinational)
- vc_hit_i  in  1  victim cache hit (combinational, valid when vc_wr_en_o=0)
- mem_req_o  out  1  memory line-read request
- mem_addr_o  out  VADDR_W  memory read address
- mem_ack_i  in  1  memory data valid, single-cycle
- mem_data_i  in  LINE_W  memory line data
- hit_cnt_o  out  STAT_W  victim hit count
- miss_cnt_o  out  STAT_W  victim miss count

Behaviour:
- Reset (rst=0, async): FSM to IDLE; all outputs and registers 0; counters 0.
- FSM states: IDLE, PROBE, MEM, VWRITE, DONE.
- IDLE:
  - When miss_req_i=1 and flush_i=0, latch miss_addr, evict_valid, evict_addr and evict_data, then go to PROBE.
  - vc_wr_en_o=0 and vc_addr_o=0 while in IDLE.
- PROBE (exactly 1 cycle):
  - Drive vc_addr_o = latched miss_addr and vc_wr_en_o=0; sample vc_hit_i and vc_data_i at the clock edge.
  - Hit: store vc_data_i into the fill register, set fill_src=1, increment hit_cnt. Next state is VWRITE if evict_valid, else DONE.
  - Miss: increment miss_cnt, go to MEM.
- MEM:
  - mem_req_o=1 and mem_addr_o = latched miss_addr, held steady until the cycle in which mem_ack_i=1.
  - On ack: latch mem_data_i, set fill_src=0, drop mem_req_o on the next cycle. Next state is VWRITE if evict_valid, else DONE.
  - Ack may arrive in the first MEM cycle.
  - mem_ack_i is ignored outside MEM.
- VWRITE (exactly 1 cycle): vc_wr_en_o=1, vc_addr_o = latched evict_addr, vc_data_o = latched evict_data; then go to DONE.
  - The victim cache performs an in-place update if the address is already present, otherwise it replaces round-robin.
- DONE (1 cycle): miss_ack_o=1 and fill_data_o = fill register; then go to IDLE.
  - fill_data_o is 0 whenever miss_ack_o=0.
- Ordering: the probe always precedes the eviction write, so an evicted line can never satisfy its own miss.
  - If evict_addr == miss_addr, the probe result still reflects the pre-write contents.
- Latency, accept edge to miss_ack_o:
  - Victim hit, no evict: 2 cycles.
  - Victim hit with evict: 3 cycles.
  - Victim miss: 3 + N cycles without evict, 4 + N with evict, where N = cycles waited in MEM for mem_ack_i (N=0 when ack comes in the first MEM cycle).
- Back-to-back requests: a new request is accepted only in IDLE, so the minimum spacing between acks is 3 cycles.
- Counters: increment by 1 and saturate at all-ones; no wrap. They are cleared only by reset, not by flush.
- flush_i (synchronous, highest priority after reset):
  - Any state goes to IDLE next cycle; mem_req_o, vc_wr_en_o and miss_ack_o are forced to 0 in that same cycle.
  - The in-flight request is dropped without an ack.
  - A pending memory ack after flush is ignored.
  - A VWRITE cycle coincident with flush is suppressed.
- Reset mid-operation: same as flush, asynchronously; no ack issued.

Decomposition:
- Package cache_defs holds DCACHE_LINE_WIDTH, VICTIM_ADDR_BITS and the typedef vc_ctrl_state_t (enum IDLE, PROBE, MEM, VWRITE, DONE).
- One sub-module, vc_sat_counter: parameter STAT_W, inputs clk/rst/inc_i, output cnt_o. It is instantiated twice, for hits and misses.

Test Plan:
- Victim hit, no evict: preload victim addr 0x0000ABC with data 0xDEAD..., then miss_req to 0x0000ABC with evict_valid=0 -> miss_ack 2 cycles after accept, fill_src=1, fill=0xDEAD..., mem_req never asserted, hit_cnt=1.
- Victim miss with evict: miss 0x0000123, evict 0x0000456 with data 0xBEEF..., memory acks after 3 wait cycles with 0xCAFE... -> mem_req high 4 cycles, one vc_wr_en pulse to 0x0000456, ack 7 cycles after accept with fill 0xCAFE..., fill_src=0, miss_cnt=1.
- Eviction of an already-present address: victim holds 0x0000456; miss with evict 0x0000456 and new data -> subsequent probe of 0x0000456 returns the new data and no other entry changes.
- Flush during MEM: flush_i asserted in the 2nd MEM cycle -> mem_req drops that cycle, no miss_ack, FSM is IDLE, a later mem_ack_i is ignored, and the next request completes normally.
- Async reset mid-PROBE: rst low for 1 cycle -> all outputs 0 immediately, counters 0, no ack.
- Counter saturation, STAT_W=2: 5 victim hits -> hit_cnt_o reads 3 and stays at 3.
